stream_checksum: RTL and testbench

//  Streaming 16-bit ones-complement (RFC 1071) checksum engine over a parametrised-width valid/ready bus.
//  - Generalises the single-word parse-and-accumulate step to DATA_W-bit beats with byte enables and framing.
//  - Adds result handshake, seed value and optional verify flag.
//  - Sits beside the packet parsers: taps header/payload beats, emits one checksum per frame.

---
 rtl/checksum_pkg.sv | 29 ++
 rtl/checksum_beat_sum.sv | 27 ++
 rtl/stream_checksum.sv | 94 +++++++++
 tb/tb_stream_checksum.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/checksum_pkg.sv
// Shared types and ones-complement arithmetic helpers for the RFC 1071 checksum datapath.
package checksum_pkg;

   typedef struct packed {
      logic [15:0] acc;
      logic        in_frame;
   } csum_state_t;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } frame_state_t;

   localparam csum_state_t CSUM_RESET = '{acc: 16'h0000, in_frame: 1'b0};

   function automatic logic [15:0] csum_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'h0000, s[16]};
   endfunction

   // Two end-around folds: the first leaves at most 17 bits, the second cannot carry again.
   function automatic logic [15:0] csum_fold(input logic [31:0] x);
      logic [16:0] t;
      t = {1'b0, x[31:16]} + {1'b0, x[15:0]};
      return t[15:0] + {15'h0000, t[16]};
   endfunction

endpackage

// File: rtl/checksum_beat_sum.sv
// Combinational ones-complement sum of one DATA_W-bit beat with per-byte enables.
module checksum_beat_sum
   import checksum_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0]   data,
   input  logic [DATA_W/8-1:0] keep,
   output logic [15:0]         sum
);

   localparam int unsigned LANES = DATA_W / 16;

   logic [31:0] total;

   // keep[2i] gates the high byte of lane i, keep[2i+1] the low byte.
   always_comb begin
      total = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         total = total + {16'h0000,
                          (keep[2*i]   ? data[16*i+8 +: 8] : 8'h00),
                          (keep[2*i+1] ? data[16*i   +: 8] : 8'h00)};
      end
      sum = csum_fold(total);
   end

endmodule

// File: rtl/stream_checksum.sv
// Streaming RFC 1071 checksum engine: one registered checksum per frame over a valid/ready bus.
// Optional CSUM_VERIFY_EN adds m_ok (final frame sum == 16'hFFFF).
module stream_checksum
   import checksum_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter logic [15:0] INIT   = 16'h0000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DATA_W-1:0]   s_data,
   input  logic [DATA_W/8-1:0] s_keep,
   input  logic                s_last,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [15:0]         m_checksum
`ifdef CSUM_VERIFY_EN
   ,
   output logic                m_ok
`endif
);

   csum_state_t  st_q, st_d;
   frame_state_t state, state_d;
   logic         accept;
   logic [15:0]  beat_sum, base, frame_sum;
   logic         m_valid_d;
   logic [15:0]  csum_d;
`ifdef CSUM_VERIFY_EN
   logic         ok_d;
`endif

   checksum_beat_sum #(
      .DATA_W (DATA_W)
   ) u_beat_sum (
      .data (s_data),
      .keep (s_keep),
      .sum  (beat_sum)
   );

   always_comb begin
      state     = st_q.in_frame ? ACCUM : IDLE;
      // Only a last beat needs the result slot; mid-frame beats flow into acc while a result is held.
      s_ready   = !m_valid || m_ready || !s_last;
      accept    = s_valid && s_ready;
      base      = (state == ACCUM) ? st_q.acc : INIT;
      frame_sum = csum_add16(base, beat_sum);

      st_d      = st_q;
      state_d   = state;
      m_valid_d = m_valid && !m_ready;
      csum_d    = m_checksum;
`ifdef CSUM_VERIFY_EN
      ok_d      = m_ok;
`endif

      if (accept) begin
         if (s_last) begin
            state_d   = IDLE;
            st_d.acc  = INIT;
            m_valid_d = 1'b1;
            csum_d    = ~frame_sum;
`ifdef CSUM_VERIFY_EN
            ok_d      = (frame_sum == 16'hFFFF);
`endif
         end else begin
            state_d  = ACCUM;
            st_d.acc = frame_sum;
         end
      end
      st_d.in_frame = (state_d == ACCUM);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         st_q       <= '{acc: INIT, in_frame: CSUM_RESET.in_frame};
         m_valid    <= 1'b0;
         m_checksum <= '0;
`ifdef CSUM_VERIFY_EN
         m_ok       <= 1'b0;
`endif
      end else begin
         st_q       <= st_d;
         m_valid    <= m_valid_d;
         m_checksum <= csum_d;
`ifdef CSUM_VERIFY_EN
         m_ok       <= ok_d;
`endif
      end
   end

endmodule

// File: tb/tb_stream_checksum.sv
// Directed self-checking bench for stream_checksum (32-bit instance plus a 128-bit seeded instance).
module tb_stream_checksum;

   logic         clk = 1'b0;
   logic         reset_n;

   logic         s_valid, s_ready, s_last, m_valid, m_ready;
   logic [31:0]  s_data;
   logic [3:0]   s_keep;
   logic [15:0]  m_checksum;
`ifdef CSUM_VERIFY_EN
   logic         m_ok;
`endif

   logic         wide_s_valid, wide_s_ready, wide_s_last, wide_m_valid, wide_m_ready;
   logic [127:0] wide_s_data;
   logic [15:0]  wide_s_keep;
   logic [15:0]  wide_m_checksum;
`ifdef CSUM_VERIFY_EN
   logic         wide_m_ok;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   stream_checksum #(
      .DATA_W (32),
      .INIT   (16'h0000)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_keep     (s_keep),
      .s_last     (s_last),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_checksum (m_checksum)
`ifdef CSUM_VERIFY_EN
      ,
      .m_ok       (m_ok)
`endif
   );

   stream_checksum #(
      .DATA_W (128),
      .INIT   (16'h1234)
   ) dut_wide (
      .clk        (clk),
      .reset_n    (reset_n),
      .s_valid    (wide_s_valid),
      .s_ready    (wide_s_ready),
      .s_data     (wide_s_data),
      .s_keep     (wide_s_keep),
      .s_last     (wide_s_last),
      .m_valid    (wide_m_valid),
      .m_ready    (wide_m_ready),
      .m_checksum (wide_m_checksum)
`ifdef CSUM_VERIFY_EN
      ,
      .m_ok       (wide_m_ok)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Present one beat, let it be accepted at the next rising edge, sample 1 time unit later.
   task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      s_keep  = k;
      s_last  = l;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   initial begin
      reset_n      = 1'b0;
      s_valid      = 1'b0;
      s_data       = '0;
      s_keep       = '0;
      s_last       = 1'b0;
      m_ready      = 1'b1;
      wide_s_valid = 1'b0;
      wide_s_data  = '0;
      wide_s_keep  = '0;
      wide_s_last  = 1'b0;
      wide_m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
      chk("reset_m_checksum", {16'd0, m_checksum}, 32'd0);
      chk("reset_s_ready", {31'd0, s_ready}, 32'd1);
`ifdef CSUM_VERIFY_EN
      chk("reset_m_ok", {31'd0, m_ok}, 32'd0);
`endif
      @(negedge clk);
      reset_n = 1'b1;

      // Two-beat frame
      beat(32'hF203_0001, 4'hF, 1'b0);
      chk("t1_no_early_valid", {31'd0, m_valid}, 32'd0);
      beat(32'hF6F7_F4F5, 4'hF, 1'b1);
      chk("t1_valid", {31'd0, m_valid}, 32'd1);
      chk("t1_csum", {16'd0, m_checksum}, 32'h0000_220D);
      @(posedge clk);
      #1;
      chk("t1_consumed", {31'd0, m_valid}, 32'd0);

      // Partial keep, single-beat frame
      beat(32'hFFFF_AB00, 4'b0001, 1'b1);
      chk("t2_csum", {16'd0, m_checksum}, 32'h0000_54FF);

      // Non-contiguous keep: only low bytes 0x22, 0x44 survive -> sum 0x0066
      beat(32'h1122_3344, 4'b1010, 1'b1);
      chk("keep_sparse_csum", {16'd0, m_checksum}, 32'h0000_FF99);

      // Empty keep contributes nothing
      beat(32'h1234_5678, 4'b0000, 1'b1);
      chk("keep_zero_csum", {16'd0, m_checksum}, 32'h0000_FFFF);

      // Verification frame: checksum field included
      beat(32'hF203_0001, 4'hF, 1'b0);
      beat(32'hF6F7_F4F5, 4'hF, 1'b0);
      beat(32'h0000_220D, 4'hF, 1'b1);
      chk("t3_good_csum", {16'd0, m_checksum}, 32'h0000_0000);
`ifdef CSUM_VERIFY_EN
      chk("t3_good_ok", {31'd0, m_ok}, 32'd1);
`endif
      beat(32'hF203_0001, 4'hF, 1'b0);
      beat(32'hF6F7_F4F5, 4'hF, 1'b0);
      beat(32'h0000_220C, 4'hF, 1'b1);
      chk("t3_bad_csum", {16'd0, m_checksum}, 32'h0000_0001);
`ifdef CSUM_VERIFY_EN
      chk("t3_bad_ok", {31'd0, m_ok}, 32'd0);
`endif
      @(posedge clk);
      #1;

      // Backpressure on the result
      m_ready = 1'b0;
      beat(32'hF203_0001, 4'hF, 1'b0);
      beat(32'hF6F7_F4F5, 4'hF, 1'b1);
      chk("t4_held_csum", {16'd0, m_checksum}, 32'h0000_220D);
      beat(32'h0000_1111, 4'hF, 1'b0);
      chk("t4_mid_accept_csum", {16'd0, m_checksum}, 32'h0000_220D);
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 32'h0000_2222;
      s_keep  = 4'hF;
      s_last  = 1'b1;
      #1;
      chk("t4_stall_ready", {31'd0, s_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("t4_stall_valid", {31'd0, m_valid}, 32'd1);
      chk("t4_stall_csum", {16'd0, m_checksum}, 32'h0000_220D);
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      chk("t4_release_ready", {31'd0, s_ready}, 32'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk("t4_frame2_valid", {31'd0, m_valid}, 32'd1);
      chk("t4_frame2_csum", {16'd0, m_checksum}, 32'h0000_CCCC);
      @(posedge clk);
      #1;
      chk("t4_frame2_consumed", {31'd0, m_valid}, 32'd0);

      // Reset mid-frame discards the partial sum
      beat(32'hF203_0001, 4'hF, 1'b0);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_reset_valid", {31'd0, m_valid}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      beat(32'hF203_0001, 4'hF, 1'b0);
      beat(32'hF6F7_F4F5, 4'hF, 1'b1);
      chk("t5_replay_csum", {16'd0, m_checksum}, 32'h0000_220D);

      // 128-bit instance with seed 0x1234
      @(negedge clk);
      wide_s_valid = 1'b1;
      wide_s_data  = {128{1'b1}};
      wide_s_keep  = 16'hFFFF;
      wide_s_last  = 1'b1;
      @(posedge clk);
      #1;
      wide_s_valid = 1'b0;
      wide_s_last  = 1'b0;
      chk("t6_wide_valid", {31'd0, wide_m_valid}, 32'd1);
      chk("t6_wide_csum", {16'd0, wide_m_checksum}, 32'h0000_EDCB);
`ifdef CSUM_VERIFY_EN
      chk("t6_wide_ok", {31'd0, wide_m_ok}, 32'd0);
`endif

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
